// File: rtl/pico_alu_if.sv
// Operand/result bundle between the register file read ports, the ALU and the writeback mux.
// The ALU takes the slave side; whoever drives operands takes the master side.
interface pico_alu_if #(
  parameter int N = 8
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   func;
  logic [N-1:0] result;
  logic         ZF;
  logic         CF;
  logic         ZF_q;
  logic         CF_q;

  modport master (
    output a, b, func,
    input  result, ZF, CF, ZF_q, CF_q
  );

  modport slave (
    input  a, b, func,
    output result, ZF, CF, ZF_q, CF_q
  );
endinterface

// File: rtl/pico_alu.sv
// N-bit unsigned pico-MIPS ALU: zero-latency result/ZF/CF.
// ZF_q and CF_q keep the previous cycle's flags for branches that issue later.
module pico_alu #(
  parameter int N = 8
) (
  input logic       clk,
  input logic       rst,
  pico_alu_if.slave bus
);
  localparam logic [2:0] RA   = 3'd0;
  localparam logic [2:0] RB   = 3'd1;
  localparam logic [2:0] RADD = 3'd2;
  localparam logic [2:0] RSUB = 3'd3;
  localparam logic [2:0] RAND = 3'd4;
  localparam logic [2:0] ROR  = 3'd5;
  localparam logic [2:0] RXOR = 3'd6;
  localparam logic [2:0] RMUL = 3'd7;

  // Returns {CF, result}. The sum and difference are formed one bit wider so
  // the top bit is the carry or borrow; the product is kept at full width so
  // any nonzero bit above N-1 signals overflow.
  function automatic logic [N:0] alu_op(input logic [N-1:0] a,
                                        input logic [N-1:0] b,
                                        input logic [2:0]   func);
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [2*N-1:0] prod;
    logic [N:0]     res;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    res  = '0;
    case (func)
      RA:   res = {1'b0, a};
      RB:   res = {1'b0, b};
      RADD: res = sum;
      RSUB: res = diff;
      RAND: res = {1'b0, a & b};
      ROR:  res = {1'b0, a | b};
      RXOR: res = {1'b0, a ^ b};
      RMUL: res = {|prod[2*N-1:N], prod[N-1:0]};
    endcase
    return res;
  endfunction

  logic [N-1:0] result;
  logic         cf;
  logic         zf;
  logic         zf_q;
  logic         cf_q;

  always_comb begin
    {cf, result} = alu_op(bus.a, bus.b, bus.func);
    zf           = (result == '0);
  end

  assign bus.result = result;
  assign bus.ZF     = zf;
  assign bus.CF     = cf;

  // Registered flag stage
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      zf_q <= zf;
      cf_q <= cf;
    end
  end

  assign bus.ZF_q = zf_q;
  assign bus.CF_q = cf_q;
endmodule

// File: tb/tb_pico_alu.sv
// Scoreboard bench for pico_alu: driver pushes model expectations on the falling edge,
// monitor pops and compares one time unit after each rising edge.
module tb_pico_alu;
  localparam int N = 8;
  localparam longint unsigned MOD = 64'd1 << N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pico_alu_if #(.N(N)) bus ();

  pico_alu #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           id;
    logic [N-1:0] res;
    logic         zf;
    logic         cf;
    logic         zfq;
    logic         cfq;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   seq   = 0;
  bit   done  = 1'b0;

  // Reference model straight from the operation table, in plain 64-bit arithmetic.
  function automatic void model(input longint unsigned a, input longint unsigned b,
                                input int f, output longint unsigned r, output bit c);
    longint unsigned full;
    c = 1'b0;
    r = 0;
    case (f)
      0: r = a;
      1: r = b;
      2: begin full = a + b; r = full % MOD; c = (full >= MOD); end
      3: begin r = (a + MOD - b) % MOD; c = (a < b); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin full = a * b; r = full % MOD; c = (full >= MOD); end
    endcase
  endfunction

  task automatic apply(input int a, input int b, input int f, input bit r);
    longint unsigned er;
    bit ec;
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.a    = N'(a);
    bus.b    = N'(b);
    bus.func = 3'(f);
    model(longint'(a), longint'(b), f, er, ec);
    e.id  = seq;
    e.res = N'(er);
    e.zf  = (er == 0);
    e.cf  = ec;
    e.zfq = r ? 1'b0 : (er == 0);
    e.cfq = r ? 1'b0 : ec;
    q.push_back(e);
    seq++;
  endtask

  task automatic check(input string name, input int id, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, id, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a pending entry is a response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("result", e.id, longint'(bus.result), longint'(e.res));
        check("ZF",     e.id, longint'(bus.ZF),     longint'(e.zf));
        check("CF",     e.id, longint'(bus.CF),     longint'(e.cf));
        check("ZF_q",   e.id, longint'(bus.ZF_q),   longint'(e.zfq));
        check("CF_q",   e.id, longint'(bus.CF_q),   longint'(e.cfq));
      end
    end
  end

  // Concurrent checks on the combinational path.
  a_ra:   assert property (@(posedge clk) (bus.func == 3'd0) |-> (bus.result == bus.a))
          else begin fails++; $display("FAIL assert_ra result=%0d", bus.result); end
  a_rb:   assert property (@(posedge clk) (bus.func == 3'd1) |-> (bus.result == bus.b))
          else begin fails++; $display("FAIL assert_rb result=%0d", bus.result); end
  a_add:  assert property (@(posedge clk) (bus.func == 3'd2) |-> (bus.result == bus.a + bus.b))
          else begin fails++; $display("FAIL assert_add result=%0d", bus.result); end
  a_sub:  assert property (@(posedge clk) (bus.func == 3'd3) |-> (bus.result == bus.a - bus.b))
          else begin fails++; $display("FAIL assert_sub result=%0d", bus.result); end
  a_and:  assert property (@(posedge clk) (bus.func == 3'd4) |-> (bus.result == (bus.a & bus.b)))
          else begin fails++; $display("FAIL assert_and result=%0d", bus.result); end
  a_or:   assert property (@(posedge clk) (bus.func == 3'd5) |-> (bus.result == (bus.a | bus.b)))
          else begin fails++; $display("FAIL assert_or result=%0d", bus.result); end
  a_xor:  assert property (@(posedge clk) (bus.func == 3'd6) |-> (bus.result == (bus.a ^ bus.b)))
          else begin fails++; $display("FAIL assert_xor result=%0d", bus.result); end
  a_mul:  assert property (@(posedge clk) (bus.func == 3'd7) |-> (bus.result == bus.a * bus.b))
          else begin fails++; $display("FAIL assert_mul result=%0d", bus.result); end
  a_zf:   assert property (@(posedge clk) (bus.result == '0) |-> bus.ZF)
          else begin fails++; $display("FAIL assert_zf ZF=%0d", bus.ZF); end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    bus.a    = '0;
    bus.b    = '0;
    bus.func = 3'd0;

    // Reset held while ZF=1: registered flags must stay cleared.
    repeat (3) apply(0, 0, 0, 1'b1);

    for (int f = 0; f < 8; f++) apply(5, 17, f, 1'b0);
    apply(17, 17, 3, 1'b0);
    apply(200, 100, 2, 1'b0);
    apply(16, 32, 7, 1'b0);
    apply(0, 9, 0, 1'b0);

    // Mid-operation reset clears only the _q flags; ZF_q follows again afterwards.
    apply(0, 9, 0, 1'b1);
    apply(0, 9, 0, 1'b0);
    apply(255, 1, 2, 1'b0);
    apply(0, 1, 3, 1'b0);
    apply(255, 255, 7, 1'b0);

    for (int i = 0; i < 400; i++)
      apply(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));

    repeat (3) @(posedge clk);
    #2;
    check("drain", seq, longint'(q.size()), 0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
